io_bridge: RTL and testbench

Parametrised I/O bus bridge between the RISC5 CPU and up to 16 memory-mapped device slots at 0xFFFFC0–0xFFFFFF. It is the registered successor of the flat combinational I/O decode/mux. Beyond decode and mux, it adds:
- single-cycle device strobes, so a device FIFO pop happens exactly once per access;
- per-access ready handshake that stalls the CPU;
- a registered read-data return path;
- an optional bus-timeout with sticky error capture.

---
 rtl/io_bridge.sv | 148 ++++++++++++++
 tb/tb_io_bridge.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/io_bridge.sv
// rtl/io_bridge.sv - registered RISC5 I/O bridge, 16 slots at 0xFFFFC0; optional bus timeout under IO_TIMEOUT_EN
module io_bridge #(
  parameter int NSLOTS  = 8,
  parameter int TIMEOUT = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [23:0]          cpu_adr,
  input  logic                 cpu_rd,
  input  logic                 cpu_wr,
  input  logic                 cpu_ben,
  input  logic [31:0]          cpu_wdata,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_wait,
  output logic                 io_sel,
  output logic [NSLOTS-1:0]    dev_en,
  output logic                 dev_rd,
  output logic                 dev_wr,
  output logic                 dev_ben,
  output logic [31:0]          dev_wdata,
  input  logic [NSLOTS*32-1:0] dev_rdata,
  input  logic [NSLOTS-1:0]    dev_rdy,
  output logic                 bus_err,
  output logic [3:0]           err_slot
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  if (NSLOTS < 1 || NSLOTS > 16 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
    $error("io_bridge: NSLOTS or TIMEOUT out of range");
  end

  logic [1:0]  state;
  logic [3:0]  slot_q;
  logic        wr_q;
  logic        first_q;
  logic [31:0] rdata_q;
  logic        req;
  logic        mapped;
  logic        rdy_sel;
  logic [31:0] rdata_sel;
  logic        tmo_hit;
  logic        unused_adr;

  assign unused_adr = ^cpu_adr[1:0];

  assign io_sel    = (cpu_adr[23:6] == 18'h3FFFF);
  assign req       = io_sel & (cpu_rd | cpu_wr);
  assign mapped    = ({1'b0, cpu_adr[5:2]} < 5'(NSLOTS));
  assign cpu_rdata = rdata_q;

  // Only the latched slot's rdy/data are visible; other slots are ignored.
  always_comb begin
    dev_en    = '0;
    rdy_sel   = 1'b0;
    rdata_sel = '0;
    for (int k = 0; k < NSLOTS; k++) begin
      if (slot_q == 4'(k)) begin
        rdy_sel   = dev_rdy[k];
        rdata_sel = dev_rdata[32*k +: 32];
        if (state == S_ACCESS) dev_en[k] = 1'b1;
      end
    end
  end

  always_comb begin
    case (state)
      S_IDLE:   cpu_wait = req;
      S_ACCESS: cpu_wait = 1'b1;
      default:  cpu_wait = 1'b0;
    endcase
  end

  assign dev_rd = (state == S_ACCESS) & first_q & ~wr_q;
  assign dev_wr = (state == S_ACCESS) & first_q &  wr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      slot_q    <= '0;
      wr_q      <= 1'b0;
      first_q   <= 1'b0;
      dev_ben   <= 1'b0;
      dev_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            if (mapped) begin
              slot_q    <= cpu_adr[5:2];
              wr_q      <= cpu_wr;
              first_q   <= 1'b1;
              dev_ben   <= cpu_ben;
              dev_wdata <= cpu_wdata;
              state     <= S_ACCESS;
            end else begin
              rdata_q <= '0;
              state   <= S_DONE;
            end
          end
        end
        S_ACCESS: begin
          first_q <= 1'b0;
          if (rdy_sel) begin
            if (!wr_q) rdata_q <= rdata_sel;
            state <= S_DONE;
          end else if (tmo_hit) begin
            rdata_q <= '0;
            state   <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef IO_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // rdy in the limit cycle takes priority, so the hit is qualified by ~rdy.
  assign tmo_hit = (state == S_ACCESS) & ~rdy_sel & (tmo_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt  <= '0;
      bus_err  <= 1'b0;
      err_slot <= '0;
    end else if (state != S_ACCESS) begin
      tmo_cnt <= '0;
    end else if (!rdy_sel) begin
      if (tmo_hit) begin
        bus_err  <= 1'b1;
        err_slot <= slot_q;
      end else begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
    end
  end
`else
  assign tmo_hit  = 1'b0;
  assign bus_err  = 1'b0;
  assign err_slot = 4'd0;
`endif

endmodule

// File: tb/tb_io_bridge.sv
// tb/tb_io_bridge.sv - directed self-checking bench for io_bridge (NSLOTS=8, TIMEOUT=16)
module tb_io_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic [23:0]  cpu_adr;
  logic         cpu_rd, cpu_wr, cpu_ben;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         cpu_wait, io_sel;
  logic [7:0]   dev_en;
  logic         dev_rd, dev_wr, dev_ben;
  logic [31:0]  dev_wdata;
  logic [255:0] dev_rdata;
  logic [7:0]   dev_rdy;
  logic         bus_err;
  logic [3:0]   err_slot;

  int vectors = 0;
  int miscompares = 0;

  io_bridge #(.NSLOTS(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .cpu_adr(cpu_adr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_ben(cpu_ben), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_wait(cpu_wait), .io_sel(io_sel), .dev_en(dev_en), .dev_rd(dev_rd),
    .dev_wr(dev_wr), .dev_ben(dev_ben), .dev_wdata(dev_wdata),
    .dev_rdata(dev_rdata), .dev_rdy(dev_rdy), .bus_err(bus_err), .err_slot(err_slot)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Stimulus driver: entered just after a posedge; runs one access to DONE.
  task automatic run_access(input logic [23:0] adr, input logic wr, input logic ben,
                            input logic [31:0] wdata, input logic [7:0] rdy_init,
                            input logic [7:0] rdy_late, input int late_after,
                            output int waits, output int rd_p, output int wr_p,
                            output logic [7:0] en_seen, output logic [31:0] wd_seen,
                            output logic ben_seen, output logic [31:0] rdata_done,
                            output logic ok);
    int acc;
    waits = 0; rd_p = 0; wr_p = 0; en_seen = '0; wd_seen = '0; ben_seen = 1'b0;
    rdata_done = '0; ok = 1'b0; acc = 0;
    cpu_adr = adr; cpu_rd = ~wr; cpu_wr = wr; cpu_ben = ben; cpu_wdata = wdata;
    dev_rdy = rdy_init;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cpu_wait) waits++;
      rd_p += int'(dev_rd);
      wr_p += int'(dev_wr);
      en_seen |= dev_en;
      if (dev_en != 8'h00) begin
        acc++;
        wd_seen  = dev_wdata;
        ben_seen = dev_ben;
      end
      if (acc > late_after) dev_rdy = rdy_init | rdy_late;
      if (!cpu_wait) begin
        rdata_done = cpu_rdata;
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_ben = 1'b0; dev_rdy = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_adr = '0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_ben = 1'b0;
    cpu_wdata = '0; dev_rdy = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if (cpu_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata got %h exp 0", cpu_rdata); end
    vectors++; if (dev_en !== 8'h00) begin miscompares++; $display("FAIL rst_dev_en got %h exp 00", dev_en); end
    vectors++; if ({dev_rd, dev_wr, dev_ben} !== 3'b000) begin miscompares++; $display("FAIL rst_strobes got %b exp 000", {dev_rd, dev_wr, dev_ben}); end
    vectors++; if (dev_wdata !== 32'h0) begin miscompares++; $display("FAIL rst_wdata got %h exp 0", dev_wdata); end
    vectors++; if ({bus_err, err_slot} !== 5'h0) begin miscompares++; $display("FAIL rst_err got %b/%h exp 0/0", bus_err, err_slot); end
    vectors++; if ({cpu_wait, io_sel} !== 2'b00) begin miscompares++; $display("FAIL rst_wait_sel got %b exp 00", {cpu_wait, io_sel}); end
    cpu_adr = 24'hFFFFC0;
    #1;
    vectors++; if ({cpu_wait, io_sel} !== 2'b01) begin miscompares++; $display("FAIL iosel_norq got %b exp 01", {cpu_wait, io_sel}); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_read_slot0();
    int w, rp, wp; logic [7:0] en; logic [31:0] wd, rd; logic b, ok;
    run_access(24'hFFFFC0, 1'b0, 1'b0, 32'h0, 8'hFF, 8'h00, 1000, w, rp, wp, en, wd, b, rd, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL rd0_done got %b exp 1", ok); end
    vectors++; if (w !== 2) begin miscompares++; $display("FAIL rd0_wait got %0d exp 2", w); end
    vectors++; if (rd !== 32'h12345678) begin miscompares++; $display("FAIL rd0_data got %h exp 12345678", rd); end
    vectors++; if (rp !== 1 || wp !== 0) begin miscompares++; $display("FAIL rd0_strobe got rd%0d wr%0d exp rd1 wr0", rp, wp); end
    vectors++; if (en !== 8'h01) begin miscompares++; $display("FAIL rd0_en got %h exp 01", en); end
  endtask

  task automatic test_write_slot3();
    int w, rp, wp; logic [7:0] en; logic [31:0] wd, rd; logic b, ok;
    run_access(24'hFFFFCC, 1'b1, 1'b1, 32'hA5A50003, 8'h00, 8'h08, 5, w, rp, wp, en, wd, b, rd, ok);
    vectors++; if (w !== 7 || ok !== 1'b1) begin miscompares++; $display("FAIL wr3_wait got %0d ok%b exp 7 ok1", w, ok); end
    vectors++; if (wp !== 1 || rp !== 0) begin miscompares++; $display("FAIL wr3_strobe got wr%0d rd%0d exp wr1 rd0", wp, rp); end
    vectors++; if (wd !== 32'hA5A50003) begin miscompares++; $display("FAIL wr3_wdata got %h exp a5a50003", wd); end
    vectors++; if (b !== 1'b1) begin miscompares++; $display("FAIL wr3_ben got %b exp 1", b); end
    vectors++; if (en !== 8'h08) begin miscompares++; $display("FAIL wr3_en got %h exp 08", en); end
    vectors++; if (rd !== 32'h12345678) begin miscompares++; $display("FAIL wr3_rdata_kept got %h exp 12345678", rd); end
  endtask

  task automatic test_rdy_isolation();
    int w, rp, wp; logic [7:0] en; logic [31:0] wd, rd; logic b, ok;
    run_access(24'hFFFFDC, 1'b0, 1'b0, 32'h0, 8'h04, 8'h80, 3, w, rp, wp, en, wd, b, rd, ok);
    vectors++; if (w !== 5 || ok !== 1'b1) begin miscompares++; $display("FAIL rd7_wait got %0d ok%b exp 5 ok1", w, ok); end
    vectors++; if (rd !== 32'hD0D00007) begin miscompares++; $display("FAIL rd7_data got %h exp d0d00007", rd); end
    vectors++; if (en !== 8'h80) begin miscompares++; $display("FAIL rd7_en got %h exp 80", en); end
  endtask

  task automatic test_reset_mid_access();
    cpu_adr = 24'hFFFFD0; cpu_rd = 1'b1; dev_rdy = '0;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (dev_rd !== 1'b1 || dev_en !== 8'h10) begin miscompares++; $display("FAIL mid_acc1 got rd%b en%h exp rd1 en10", dev_rd, dev_en); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (dev_rd !== 1'b0) begin miscompares++; $display("FAIL mid_acc2_rd got %b exp 0", dev_rd); end
    @(negedge clk);
    vectors++; if (dev_en !== 8'h00 || dev_rd !== 1'b0) begin miscompares++; $display("FAIL mid_idle got en%h rd%b exp en00 rd0", dev_en, dev_rd); end
    vectors++; if (cpu_rdata !== 32'h0) begin miscompares++; $display("FAIL mid_rdata got %h exp 0", cpu_rdata); end
    vectors++; if (cpu_wait !== 1'b1) begin miscompares++; $display("FAIL mid_wait_idle got %b exp 1", cpu_wait); end
    cpu_rd = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int w, rp, wp; logic [7:0] en; logic [31:0] wd, rd; logic b, ok;
    run_access(24'hFFFFC8, 1'b0, 1'b0, 32'h0, 8'hFF, 8'h00, 1000, w, rp, wp, en, wd, b, rd, ok);
    vectors++; if (rd !== 32'hD0D00002 || w !== 2) begin miscompares++; $display("FAIL b2b_first got %h w%0d exp d0d00002 w2", rd, w); end
    run_access(24'hFFFFD8, 1'b0, 1'b0, 32'h0, 8'hFF, 8'h00, 1000, w, rp, wp, en, wd, b, rd, ok);
    vectors++; if (rd !== 32'hD0D00006 || w !== 2) begin miscompares++; $display("FAIL b2b_second got %h w%0d exp d0d00006 w2", rd, w); end
    vectors++; if (rp !== 1 || en !== 8'h40) begin miscompares++; $display("FAIL b2b_strobe got rd%0d en%h exp rd1 en40", rp, en); end
  endtask

  task automatic test_unmapped();
    int w, rp, wp; logic [7:0] en; logic [31:0] wd, rd; logic b, ok;
    run_access(24'hFFFFFC, 1'b0, 1'b0, 32'h0, 8'hFF, 8'h00, 1000, w, rp, wp, en, wd, b, rd, ok);
    vectors++; if (w !== 1 || ok !== 1'b1) begin miscompares++; $display("FAIL unmap_wait got %0d ok%b exp 1 ok1", w, ok); end
    vectors++; if (en !== 8'h00 || rp !== 0 || wp !== 0) begin miscompares++; $display("FAIL unmap_strobe got en%h rd%0d wr%0d exp 00 0 0", en, rp, wp); end
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL unmap_rdata got %h exp 0", rd); end
  endtask

  task automatic test_timeout();
    int w, rp, wp; logic [7:0] en; logic [31:0] wd, rd; logic b, ok;
`ifdef IO_TIMEOUT_EN
    run_access(24'hFFFFD4, 1'b0, 1'b0, 32'h0, 8'h00, 8'h00, 1000, w, rp, wp, en, wd, b, rd, ok);
    vectors++; if (w !== 17 || ok !== 1'b1) begin miscompares++; $display("FAIL tmo_wait got %0d ok%b exp 17 ok1", w, ok); end
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL tmo_rdata got %h exp 0", rd); end
    vectors++; if (bus_err !== 1'b1 || err_slot !== 4'd5) begin miscompares++; $display("FAIL tmo_err got %b/%0d exp 1/5", bus_err, err_slot); end
    run_access(24'hFFFFC4, 1'b0, 1'b0, 32'h0, 8'hFF, 8'h00, 1000, w, rp, wp, en, wd, b, rd, ok);
    vectors++; if (rd !== 32'hD0D00001 || w !== 2) begin miscompares++; $display("FAIL tmo_next got %h w%0d exp d0d00001 w2", rd, w); end
    vectors++; if (bus_err !== 1'b1 || err_slot !== 4'd5) begin miscompares++; $display("FAIL tmo_sticky got %b/%0d exp 1/5", bus_err, err_slot); end
`else
    run_access(24'hFFFFC4, 1'b0, 1'b0, 32'h0, 8'h00, 8'h02, 20, w, rp, wp, en, wd, b, rd, ok);
    vectors++; if (w !== 22 || rd !== 32'hD0D00001) begin miscompares++; $display("FAIL notmo_wait got w%0d %h exp w22 d0d00001", w, rd); end
    vectors++; if (bus_err !== 1'b0 || err_slot !== 4'd0) begin miscompares++; $display("FAIL notmo_err got %b/%0d exp 0/0", bus_err, err_slot); end
`endif
  endtask

  initial begin
    for (int k = 0; k < 8; k++) dev_rdata[32*k +: 32] = 32'hD0D00000 | 32'(k);
    dev_rdata[31:0] = 32'h12345678;
    test_reset();
    test_read_slot0();
    test_write_slot3();
    test_rdy_isolation();
    test_reset_mid_access();
    test_back_to_back();
    test_unmapped();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
